// File: rtl/udp_bridge_pkg.sv
// Shared definitions for the UDP bridge link controller: FSM state encoding,
// core status bit positions and a small state-classification helper.
package udp_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RUN   = 3'd4,
        ST_DRAIN = 3'd5,
        ST_FAULT = 3'd6
    } link_state_e;

    localparam int STS_READY   = 0;
    localparam int STS_ACT     = 1;
    localparam int STS_ERR     = 2;
    localparam int TIMER_MIN_W = 20;

    // States in which the core enable line is driven high.
    function automatic logic is_enabled_state(input link_state_e s);
        return (s == ST_START) || (s == ST_WAIT) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/udp_bridge_status_sync.sv
// Two-flop synchronizer bringing the core's status bits into the clk domain.
module udp_bridge_status_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r   <= '0;
            sync_out <= '0;
        end else begin
            meta_r   <= async_in;
            sync_out <= meta_r;
        end
    end

endmodule

// File: rtl/udp_bridge_link_ctrl.sv
// Link sequencer for the UDP bridge core: bring-up with timeout/retry, drain,
// and address reconfiguration that only ever lands while the core is disabled.
module udp_bridge_link_ctrl
    import udp_bridge_pkg::*;
#(
    parameter logic [47:0] DEFAULT_MAC   = 48'h02_00_00_00_00_01,
    parameter logic [31:0] DEFAULT_IP    = 32'hC0A8_0001,
    parameter int          READY_TIMEOUT = 1_000_000,
    parameter int          DRAIN_CYCLES  = 1024,
    parameter int          MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        cfg_write,
    input  logic [47:0] cfg_mac,
    input  logic [31:0] cfg_ip,
    output logic        cfg_ack,
    output logic        ethio_enable,
    input  logic [2:0]  ethio_status,
    output logic [47:0] macaddr_value,
    output logic [31:0] ipaddr_value,
    output logic        link_up,
    output logic        fault,
    output logic [3:0]  retry_count,
    output logic [2:0]  state
);

    localparam int TMAX = (READY_TIMEOUT > DRAIN_CYCLES) ? READY_TIMEOUT : DRAIN_CYCLES;
    localparam int TW   = ($clog2(TMAX) > TIMER_MIN_W) ? $clog2(TMAX) : TIMER_MIN_W;

    link_state_e state_r, state_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [3:0]    retry_r, retry_s;
    logic          pend_r, pend_s;
    logic [47:0]   pend_mac_r;
    logic [31:0]   pend_ip_r;
    logic          apply_s;
    logic [47:0]   apply_mac_s;
    logic [31:0]   apply_ip_s;
    logic [2:0]    sts_sync_s;
    logic          sts_act_unused_s;

    udp_bridge_status_sync #(.WIDTH(3)) u_status_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (ethio_status),
        .sync_out (sts_sync_s)
    );

    assign sts_act_unused_s = sts_sync_s[STS_ACT];

    // Next-state, timer, retry and config-apply decisions.
    always_comb begin
        state_s     = state_r;
        timer_s     = timer_r;
        retry_s     = retry_r;
        apply_s     = 1'b0;
        pend_s      = pend_r | cfg_write;
        // A write landing in the APPLY cycle itself bypasses the pending regs.
        apply_mac_s = cfg_write ? cfg_mac : pend_mac_r;
        apply_ip_s  = cfg_write ? cfg_ip  : pend_ip_r;
        case (state_r)
            ST_IDLE: begin
                if (run) state_s = ST_APPLY;
                else     state_s = ST_IDLE;
            end
            ST_APPLY: begin
                apply_s = pend_r | cfg_write;
                pend_s  = 1'b0;
                state_s = ST_START;
            end
            ST_START: begin
                timer_s = '0;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (sts_sync_s[STS_READY]) begin
                    state_s = ST_RUN;
                    retry_s = 4'd0;
                end else if (timer_r == TW'(READY_TIMEOUT - 1)) begin
                    retry_s = retry_r + 4'd1;
                    timer_s = '0;
                    if ((retry_r + 4'd1) == 4'(MAX_RETRY)) state_s = ST_FAULT;
                    else                                   state_s = ST_DRAIN;
                end else if (!run) begin
                    timer_s = '0;
                    state_s = ST_DRAIN;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ST_RUN: begin
                if (sts_sync_s[STS_ERR] || !run || pend_r || !sts_sync_s[STS_READY]) begin
                    timer_s = '0;
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (timer_r == TW'(DRAIN_CYCLES - 1)) begin
                    if (run) state_s = ST_APPLY;
                    else     state_s = ST_IDLE;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ST_FAULT: begin
                if (!run) begin
                    state_s = ST_IDLE;
                    retry_s = 4'd0;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, config registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            timer_r       <= '0;
            retry_r       <= 4'd0;
            pend_r        <= 1'b0;
            pend_mac_r    <= 48'd0;
            pend_ip_r     <= 32'd0;
            macaddr_value <= DEFAULT_MAC;
            ipaddr_value  <= DEFAULT_IP;
            cfg_ack       <= 1'b0;
            ethio_enable  <= 1'b0;
            link_up       <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            retry_r      <= retry_s;
            pend_r       <= pend_s;
            cfg_ack      <= apply_s;
            ethio_enable <= is_enabled_state(state_s);
            link_up      <= (state_s == ST_RUN);
            fault        <= (state_s == ST_FAULT);
            if (cfg_write) begin
                pend_mac_r <= cfg_mac;
                pend_ip_r  <= cfg_ip;
            end
            if (apply_s) begin
                macaddr_value <= apply_mac_s;
                ipaddr_value  <= apply_ip_s;
            end
        end
    end

    assign retry_count = retry_r;
    assign state       = state_r;

endmodule

// File: tb/tb_udp_bridge_link_ctrl.sv
// Randomized self-checking bench for udp_bridge_link_ctrl with short timeouts;
// expectations come from the link rules (durations, last-write-wins, single ack).
module tb_udp_bridge_link_ctrl;

    localparam int          TO      = 100;
    localparam int          DC      = 8;
    localparam int          MR      = 3;
    localparam logic [47:0] DEF_MAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] DEF_IP  = 32'hC0A8_0001;

    logic        clk = 1'b0;
    logic        reset, run, cfg_write, cfg_ack, ethio_enable, link_up, fault;
    logic [47:0] cfg_mac, macaddr_value;
    logic [31:0] cfg_ip, ipaddr_value;
    logic [2:0]  ethio_status, state;
    logic [3:0]  retry_count;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;

    udp_bridge_link_ctrl #(
        .READY_TIMEOUT (TO),
        .DRAIN_CYCLES  (DC),
        .MAX_RETRY     (MR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .cfg_write     (cfg_write),
        .cfg_mac       (cfg_mac),
        .cfg_ip        (cfg_ip),
        .cfg_ack       (cfg_ack),
        .ethio_enable  (ethio_enable),
        .ethio_status  (ethio_status),
        .macaddr_value (macaddr_value),
        .ipaddr_value  (ipaddr_value),
        .link_up       (link_up),
        .fault         (fault),
        .retry_count   (retry_count),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] cur(input int which);
        case (which)
            0:       return {2'b00, ethio_enable};
            1:       return {2'b00, link_up};
            2:       return state;
            default: return {2'b00, fault};
        endcase
    endfunction

    // Wait (bounded) until the selected signal reaches val; n = samples taken.
    task automatic wait_cond(input string tag, input int which, input logic [2:0] val,
                             input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cur(which) !== val && n < bound);
        check_eq(tag, 64'(cur(which)), 64'(val));
    endtask

    // Address outputs may only move after a sample with the core disabled.
    logic [47:0] prev_mac;
    logic [31:0] prev_ip;
    logic        prev_en;
    logic        prev_rst = 1'b1;
    always @(negedge clk) begin
        if (!reset && !prev_rst && (macaddr_value !== prev_mac || ipaddr_value !== prev_ip))
            check_eq("addr_chg_en", 64'(prev_en), 64'd0);
        if (!reset && cfg_ack) ack_cnt++;
        prev_mac = macaddr_value;
        prev_ip  = ipaddr_value;
        prev_en  = ethio_enable;
        prev_rst = reset;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, d, a0, nw;
        logic [63:0] r64;
        logic [47:0] exp_mac, last_mac;
        logic [31:0] exp_ip, last_ip;

        reset = 1'b1; run = 1'b0; cfg_write = 1'b0;
        cfg_mac = 48'd0; cfg_ip = 32'd0; ethio_status = 3'b000;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_en",    64'(ethio_enable), 64'd0);
        check_eq("rst_mac",   64'(macaddr_value), 64'(DEF_MAC));
        check_eq("rst_ip",    64'(ipaddr_value), 64'(DEF_IP));
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_link",  64'(link_up), 64'd0);
        check_eq("rst_fault", 64'(fault), 64'd0);
        check_eq("rst_retry", 64'(retry_count), 64'd0);
        check_eq("rst_ack",   64'(cfg_ack), 64'd0);
        exp_mac = DEF_MAC;
        exp_ip  = DEF_IP;

        // Bring-up: IDLE -> APPLY -> START puts enable high two samples after run.
        run = 1'b1;
        wait_cond("en_up", 0, 3'd1, 10, n);
        check_eq("en_lat",   64'(n), 64'd2);
        check_eq("st_start", 64'(state), 64'd2);
        check_eq("ack_none", 64'(cfg_ack), 64'd0);
        d = $urandom_range(60, 5);
        repeat (d) @(negedge clk);
        check_eq("st_wait", 64'(state), 64'd3);
        ethio_status = 3'b001;
        wait_cond("link_up", 1, 3'd1, 6, n);
        check_eq("link_lat_ok", 64'(n >= 2 && n <= 3), 64'd1);
        check_eq("run_retry",   64'(retry_count), 64'd0);
        check_eq("run_state",   64'(state), 64'd4);

        // Reconfigure while running: drain, apply with core off, single ack.
        r64 = {$urandom(), $urandom()};
        last_mac = r64[47:0];
        last_ip  = $urandom();
        a0 = ack_cnt;
        cfg_mac = last_mac; cfg_ip = last_ip; cfg_write = 1'b1;
        @(negedge clk);
        cfg_write = 1'b0;
        wait_cond("drain_en0", 0, 3'd0, 5, n);
        wait_cond("drain_en1", 0, 3'd1, 40, n);
        check_eq("drain_len", 64'(n), 64'(DC + 1));
        check_eq("cfg_mac",   64'(macaddr_value), 64'(last_mac));
        check_eq("cfg_ip",    64'(ipaddr_value), 64'(last_ip));
        check_eq("cfg_ack",   64'(cfg_ack), 64'd1);
        exp_mac = last_mac; exp_ip = last_ip;
        wait_cond("relink", 1, 3'd1, 8, n);
        check_eq("ack_once", 64'(ack_cnt - a0), 64'd1);

        // Core error pulse of three cycles forces a drain and re-bring-up.
        a0 = ack_cnt;
        ethio_status = 3'b101;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 3) ethio_status = 3'b001;
        end while (ethio_enable && n < 8);
        ethio_status = 3'b001;
        check_eq("err_drain",  64'(ethio_enable), 64'd0);
        check_eq("err_lat_ok", 64'(n <= 3), 64'd1);
        wait_cond("err_en1", 0, 3'd1, 40, n);
        check_eq("err_gap", 64'(n), 64'(DC + 1));
        wait_cond("err_relink", 1, 3'd1, 8, n);
        check_eq("err_mac",    64'(macaddr_value), 64'(exp_mac));
        check_eq("err_no_ack", 64'(ack_cnt - a0), 64'd0);

        // Ready never arrives: MR timeouts of TO+1 enabled cycles each, then FAULT.
        run = 1'b0; ethio_status = 3'b000;
        wait_cond("idle1", 2, 3'd0, 30, n);
        run = 1'b1;
        for (int k = 1; k <= MR; k++) begin
            wait_cond("to_en1", 0, 3'd1, 20, n);
            if (k > 1) check_eq("to_gap", 64'(n), 64'(DC + 1));
            wait_cond("to_en0", 0, 3'd0, TO + 20, n);
            check_eq("to_len",   64'(n), 64'(TO + 1));
            check_eq("to_retry", 64'(retry_count), 64'(k));
            check_eq("to_fault", 64'(fault), 64'(k == MR));
            check_eq("to_state", 64'(state), (k == MR) ? 64'd6 : 64'd5);
        end
        repeat (5) @(negedge clk);
        check_eq("fault_hold", 64'(fault), 64'd1);
        check_eq("fault_en",   64'(ethio_enable), 64'd0);
        run = 1'b0;
        @(negedge clk);
        check_eq("fault_exit_st",    64'(state), 64'd0);
        check_eq("fault_exit_flt",   64'(fault), 64'd0);
        check_eq("fault_exit_retry", 64'(retry_count), 64'd0);

        // Bursts of back-to-back writes in IDLE: last one wins, one ack.
        for (int it = 0; it < 3; it++) begin
            nw = $urandom_range(3, 1);
            for (int w = 0; w < nw; w++) begin
                r64 = {$urandom(), $urandom()};
                last_mac = r64[47:0];
                last_ip  = $urandom();
                cfg_mac = last_mac; cfg_ip = last_ip; cfg_write = 1'b1;
                @(negedge clk);
            end
            cfg_write = 1'b0;
            a0 = ack_cnt;
            ethio_status = 3'b001;
            repeat (3) @(negedge clk);
            run = 1'b1;
            wait_cond("b2b_en1", 0, 3'd1, 10, n);
            check_eq("b2b_mac", 64'(macaddr_value), 64'(last_mac));
            check_eq("b2b_ip",  64'(ipaddr_value), 64'(last_ip));
            check_eq("b2b_ack", 64'(cfg_ack), 64'd1);
            exp_mac = last_mac; exp_ip = last_ip;
            wait_cond("b2b_link", 1, 3'd1, 8, n);
            run = 1'b0;
            wait_cond("b2b_idle", 2, 3'd0, 30, n);
            check_eq("b2b_ack_cnt", 64'(ack_cnt - a0), 64'd1);
        end

        // Asynchronous reset in WAIT: enable and addresses drop without a clock edge.
        ethio_status = 3'b000;
        run = 1'b1;
        wait_cond("wr_en1", 0, 3'd1, 10, n);
        repeat (5) @(negedge clk);
        check_eq("wr_state", 64'(state), 64'd3);
        check_eq("wr_mac",   64'(macaddr_value), 64'(exp_mac));
        #2 reset = 1'b1;
        #1;
        check_eq("ar_en",    64'(ethio_enable), 64'd0);
        check_eq("ar_mac",   64'(macaddr_value), 64'(DEF_MAC));
        check_eq("ar_ip",    64'(ipaddr_value), 64'(DEF_IP));
        check_eq("ar_state", 64'(state), 64'd0);
        check_eq("ar_retry", 64'(retry_count), 64'd0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_en", 64'(ethio_enable), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
